// File: rtl/tdm_demux_1_2.sv
// Receive-side TDM demultiplexer: steers valid beats into lane shadow registers,
// aligned by a SYNC marker on lane 0, and publishes each complete frame on F with an FV strobe.
module tdm_demux_1_2 #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH-1:0]          D,
  input  logic                      V,
  input  logic                      SYNC,
  output logic [CHANNELS*WIDTH-1:0] F,
  output logic                      FV,
  output logic [SEL_W-1:0]          S,
  output logic                      ERR
);

  typedef enum logic {HUNT, LOCK} state_t;

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0] LANE_ONE  = SEL_W'(1);

  state_t                      state_q, state_d;
  logic [SEL_W-1:0]            s_q, s_d;
  logic [CHANNELS*WIDTH-1:0]   shadow_q, shadow_d;
  logic [CHANNELS*WIDTH-1:0]   f_q, f_d;
  logic                        fv_q, fv_d;
  logic                        err_q, err_d;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    shadow_d = shadow_q;
    f_d      = f_q;
    fv_d     = 1'b0;
    err_d    = err_q;
    if (V) begin
      unique case (state_q)
        HUNT: begin
          if (SYNC) begin
            shadow_d[WIDTH-1:0] = D;
            s_d                 = LANE_ONE;
            state_d             = LOCK;
          end
        end
        LOCK: begin
          if (SYNC && (s_q != '0)) begin
            // Misaligned marker: abandon the partial frame and restart at lane 0.
            err_d               = 1'b1;
            shadow_d[WIDTH-1:0] = D;
            s_d                 = LANE_ONE;
          end else begin
            shadow_d[int'(s_q)*WIDTH +: WIDTH] = D;
            if (s_q == LAST_LANE) begin
              f_d  = shadow_d;
              fv_d = 1'b1;
              s_d  = '0;
            end else begin
              s_d = s_q + LANE_ONE;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= HUNT;
      s_q      <= '0;
      shadow_q <= '0;
      f_q      <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      shadow_q <= shadow_d;
      f_q      <= f_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  assign F   = f_q;
  assign FV  = fv_q;
  assign S   = s_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_tdm_demux_1_2.sv
// Scoreboard bench for tdm_demux_1_2 (WIDTH=1, CHANNELS=2): expected frames are queued
// with the closing beat and popped by a monitor on every FV strobe.
module tb_tdm_demux_1_2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [0:0] D = 1'b0;
  logic       V = 1'b0;
  logic       SYNC = 1'b0;
  logic [1:0] F;
  logic       FV;
  logic [0:0] S;
  logic       ERR;

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;
  int fv_expected = 0;
  logic [1:0] exp_q[$];

  tdm_demux_1_2 #(.WIDTH(1), .CHANNELS(2), .SEL_W(1)) dut (
    .CLK (CLK),
    .RST (RST),
    .D   (D),
    .V   (V),
    .SYNC(SYNC),
    .F   (F),
    .FV  (FV),
    .S   (S),
    .ERR (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every FV strobe must match the oldest queued frame.
  always @(posedge CLK) begin
    logic [1:0] e;
    #1;
    if (FV === 1'b1) begin
      fv_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_fv", 32'(F), 32'h0);
        check("unexpected_fv_strobe", 32'(FV), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("frame_F", 32'(F), 32'(e));
      end
    end
  end

  task automatic beat(input logic v, input logic s, input logic d);
    @(negedge CLK);
    V = v; SYNC = s; D = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic frame_end(input logic s, input logic d, input logic [1:0] exp_f);
    exp_q.push_back(exp_f);
    fv_expected++;
    beat(1'b1, s, d);
  endtask

  task automatic idle();
    beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    V = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("rst_F", 32'(F), 32'h0);
    check("rst_S", 32'(S), 32'h0);
    check("rst_FV", 32'(FV), 32'h0);
    check("rst_ERR", 32'(ERR), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: asynchronous reset with random inputs, before any clock edge
    #1;
    RST = 1'b1;
    V = 1'($urandom_range(0, 1)); SYNC = 1'($urandom_range(0, 1)); D = 1'($urandom_range(0, 1));
    #1;
    check("t1_F", 32'(F), 32'h0);
    check("t1_FV", 32'(FV), 32'h0);
    check("t1_S", 32'(S), 32'h0);
    check("t1_ERR", 32'(ERR), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    V = 1'b0;
    RST = 1'b0;

    // 2: single frame A=1, B=0 -> F=01
    beat(1'b1, 1'b1, 1'b1);
    check("t2_S_after_lane0", 32'(S), 32'h1);
    check("t2_FV_after_lane0", 32'(FV), 32'h0);
    frame_end(1'b0, 1'b0, 2'b01);
    check("t2_F", 32'(F), 32'h1);
    check("t2_FV", 32'(FV), 32'h1);
    check("t2_S", 32'(S), 32'h0);
    idle();
    check("t2_FV_one_cycle", 32'(FV), 32'h0);

    // 3: gaps between lane beats
    beat(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("t3_S_gap", 32'(S), 32'h1);
      check("t3_F_hold", 32'(F), 32'h1);
      check("t3_FV_gap", 32'(FV), 32'h0);
    end
    frame_end(1'b0, 1'b1, 2'b11);
    check("t3_F", 32'(F), 32'h3);
    check("t3_S", 32'(S), 32'h0);

    // 4: hunting ignores non-SYNC beats
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b0, 1'b1);
      check("t4_S_hunt", 32'(S), 32'h0);
      check("t4_F_hunt", 32'(F), 32'h0);
      check("t4_FV_hunt", 32'(FV), 32'h0);
    end
    beat(1'b1, 1'b1, 1'b0);
    check("t4_S_sync", 32'(S), 32'h1);
    frame_end(1'b0, 1'b1, 2'b10);
    check("t4_F", 32'(F), 32'h2);

    // 5: misaligned SYNC sets sticky ERR and drops the partial frame
    beat(1'b1, 1'b1, 1'b1);
    check("t5_S_lane0", 32'(S), 32'h1);
    beat(1'b1, 1'b1, 1'b0);
    check("t5_ERR", 32'(ERR), 32'h1);
    check("t5_S_resync", 32'(S), 32'h1);
    check("t5_FV_dropped", 32'(FV), 32'h0);
    check("t5_F_hold", 32'(F), 32'h2);
    frame_end(1'b0, 1'b1, 2'b10);
    check("t5_F", 32'(F), 32'h2);
    idle();
    check("t5_ERR_sticky", 32'(ERR), 32'h1);

    // 6: back-to-back frames (A,B)=00,01,10,11 -> F=00,10,01,11
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ab;
      ab = 2'(k);
      beat(1'b1, 1'b1, ab[1]);
      check("t6_FV_lane0", 32'(FV), 32'h0);
      frame_end(1'b0, ab[0], {ab[0], ab[1]});
      check("t6_FV_lane1", 32'(FV), 32'h1);
      check("t6_F", 32'(F), 32'({ab[0], ab[1]}));
    end
    check("t6_ERR_clear", 32'(ERR), 32'h0);
    beat(1'b1, 1'b1, 1'b1);
    check("t6_S_mid", 32'(S), 32'h1);
    pulse_reset();
    beat(1'b1, 1'b0, 1'b1);
    check("t6_hunt_S", 32'(S), 32'h0);
    check("t6_hunt_FV", 32'(FV), 32'h0);
    idle();
    idle();

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("fv_count", 32'(fv_seen), 32'(fv_expected));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
